alu_op_sequencer: RTL

Sequencer for the 4-bit combinational ALU. It latches operands on a start request and drives the ALU `sel` for a single operation or a sweep of all eight operations. After each operation it captures the ALU result and flags, then holds them for a programmable number of cycles so the 4-digit display controller can show them. It sits between the switch/button inputs and the `alu`/`controller_4_display` pair in the practice top level.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/hold_timer.sv | 42 ++++
 rtl/alu_op_sequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the 4-bit ALU practice design: default widths,
// opcode range and the operation-sequencer state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package alu_pkg;

    // Default datapath widths
    localparam int unsigned DATA_W_DEF  = 4;
    localparam int unsigned SEL_W_DEF   = 3;
    localparam int unsigned FLAGS_W_DEF = 8;

    // Opcode range walked by a sweep
    localparam int unsigned OP_FIRST = 0;
    localparam int unsigned OP_LAST  = 7;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } seq_state_e;

endpackage : alu_pkg

// File: rtl/hold_timer.sv
// ---------------------------------------------------------------------------
// hold_timer
// Counts display-hold cycles for the operation sequencer.
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   i_clr        in   synchronous clear of the count
//   i_en         in   count enable (one count per enabled cycle)
//   o_expired_c  out  high (combinational) in the HOLD_CYCLES-th enabled cycle
// ---------------------------------------------------------------------------
module hold_timer
    import alu_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired_c
);

    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    // Count enabled cycles; saturate on the last one so the count never wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != LAST_CNT)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Count starts at 0 in the first enabled cycle, so expiry is at HOLD_CYCLES-1
    assign o_expired_c = i_en && (r_count == LAST_CNT);

endmodule : hold_timer

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
// Latches operands on start, drives the ALU opcode for one operation or a
// sweep of all eight, captures each result/flag set and holds it for
// HOLD_CYCLES cycles so the display can show it.
// Ports:
//   clk, rst            clock / synchronous active-high reset
//   start, abort        run request (IDLE only) / cancel current run
//   sweep, op_in        mode select / opcode for single mode
//   a, b                operands, latched on accepted start
//   alu_s, alu_flags    ALU result and flags
//   alu_a, alu_b        registered operands to ALU
//   alu_sel             registered opcode to ALU
//   res_q, flags_q      captured result and flags
//   op_q                opcode that produced res_q
//   res_valid           one-cycle pulse per capture
//   busy                high in EXEC and HOLD
//   done                one-cycle pulse at run completion
// ---------------------------------------------------------------------------
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned SEL_W       = SEL_W_DEF,
    parameter int unsigned FLAGS_W     = FLAGS_W_DEF,
    parameter int unsigned HOLD_CYCLES = 100_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               sweep,
    input  logic [SEL_W-1:0]   op_in,
    input  logic [DATA_W-1:0]  a,
    input  logic [DATA_W-1:0]  b,
    input  logic [DATA_W-1:0]  alu_s,
    input  logic [FLAGS_W-1:0] alu_flags,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [SEL_W-1:0]   alu_sel,
    output logic [DATA_W-1:0]  res_q,
    output logic [FLAGS_W-1:0] flags_q,
    output logic [SEL_W-1:0]   op_q,
    output logic               res_valid,
    output logic               busy,
    output logic               done
);

    seq_state_e r_state;
    seq_state_e w_state_nxt;

    logic [DATA_W-1:0]  r_alu_a;
    logic [DATA_W-1:0]  r_alu_b;
    logic [SEL_W-1:0]   r_alu_sel;
    logic [DATA_W-1:0]  r_res_q;
    logic [FLAGS_W-1:0] r_flags_q;
    logic [SEL_W-1:0]   r_op_q;
    logic               r_res_valid;
    logic               r_busy;
    logic               r_done;
    logic               r_sweep;

    logic w_expired;
    logic w_last_op;
    logic w_load;
    logic w_capture;
    logic w_step;
    logic w_tmr_clr;
    logic w_tmr_en;
    logic w_busy_nxt;
    logic w_done_nxt;

    assign w_last_op = (r_alu_sel == SEL_W'(OP_LAST));

    // Hold-time counter: cleared in EXEC, counts through HOLD
    hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_tmr_clr),
        .i_en        (w_tmr_en),
        .o_expired_c (w_expired)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state; abort outranks expiry in every active state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start && !abort) begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_nxt = abort ? ST_IDLE : ST_HOLD;
            end
            ST_HOLD: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_expired) begin
                    w_state_nxt = (r_sweep && !w_last_op) ? ST_EXEC : ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Per-state control strobes and next values of the status outputs
    always_comb begin
        w_load     = 1'b0;
        w_capture  = 1'b0;
        w_step     = 1'b0;
        w_tmr_clr  = 1'b0;
        w_tmr_en   = 1'b0;
        w_busy_nxt = (w_state_nxt == ST_EXEC) || (w_state_nxt == ST_HOLD);
        w_done_nxt = (w_state_nxt == ST_DONE);
        case (r_state)
            ST_IDLE: begin
                w_load = start && !abort;
            end
            ST_EXEC: begin
                w_capture = !abort;
                w_tmr_clr = 1'b1;
            end
            ST_HOLD: begin
                w_tmr_en = 1'b1;
                w_step   = !abort && w_expired && r_sweep && !w_last_op;
            end
            default: begin
            end
        endcase
    end

    // Operand/opcode latch, result capture and registered status
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_sel   <= '0;
            r_sweep     <= 1'b0;
            r_res_q     <= '0;
            r_flags_q   <= '0;
            r_op_q      <= '0;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (w_load) begin
                r_alu_a   <= a;
                r_alu_b   <= b;
                r_alu_sel <= sweep ? SEL_W'(OP_FIRST) : op_in;
                r_sweep   <= sweep;
            end else if (w_step) begin
                r_alu_sel <= r_alu_sel + SEL_W'(1);
            end
            if (w_capture) begin
                r_res_q   <= alu_s;
                r_flags_q <= alu_flags;
                r_op_q    <= r_alu_sel;
            end
            r_res_valid <= w_capture;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_sel   = r_alu_sel;
    assign res_q     = r_res_q;
    assign flags_q   = r_flags_q;
    assign op_q      = r_op_q;
    assign res_valid = r_res_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule : alu_op_sequencer
